// File: rtl/decommutator_if.sv
// ---------------------------------------------------------------------------
// decommutator_if : received byte stream in, per-channel write strobes out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface decommutator_if #(
    parameter int NCH = 3
);
    logic           in_valid;
    logic [7:0]     in_data;
    logic [7:0]     ch_data;
    logic [NCH-1:0] ch_wr;
    logic           ch_last;
    logic           idle_seen;
    logic           frame_err;
    logic [7:0]     err_cnt;

    modport master (
        output in_valid, in_data,
        input  ch_data, ch_wr, ch_last, idle_seen, frame_err, err_cnt
    );

    modport slave (
        input  in_valid, in_data,
        output ch_data, ch_wr, ch_last, idle_seen, frame_err, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/decommutator.sv
// ---------------------------------------------------------------------------
// decommutator : parses {F<ch>, length, payload} frames and strobes each
//                payload byte to its channel; flags idle frames and errors.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decommutator #(
    parameter int         NCH     = 3,
    parameter int         PLEN    = 9,
    parameter logic [3:0] IDLE_CH = 4'hF
) (
    input  logic                clk,
    input  logic                arst,
    decommutator_if.slave       bus
);
    localparam int         CW     = $clog2(PLEN + 1);
    localparam logic [3:0] NCH_C  = 4'(NCH);
    localparam logic [7:0] PLEN_C = 8'(PLEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(PLEN - 1);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [3:0]     ch, ch_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [7:0]     data_nx;
    logic [NCH-1:0] wr_nx;
    logic           last_nx;
    logic           idle_nx;
    logic           err_nx;

    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        cnt_nx   = cnt;
        data_nx  = bus.ch_data;
        wr_nx    = '0;
        last_nx  = 1'b0;
        idle_nx  = 1'b0;
        err_nx   = 1'b0;

        if (bus.in_valid) begin
            case (state)
                S_HUNT: begin
                    // Non-header bytes are dropped silently so we can resync mid-stream.
                    if (bus.in_data[7:4] == 4'hF) begin
                        if (bus.in_data[3:0] < NCH_C || bus.in_data[3:0] == IDLE_CH) begin
                            ch_nx    = bus.in_data[3:0];
                            state_nx = S_LEN;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    state_nx = S_HUNT;
                    if (ch == IDLE_CH) begin
                        if (bus.in_data == 8'h00) idle_nx = 1'b1;
                        else                      err_nx  = 1'b1;
                    end else if (bus.in_data == PLEN_C) begin
                        cnt_nx   = '0;
                        state_nx = S_DATA;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                S_DATA: begin
                    data_nx = bus.in_data;
                    for (int i = 0; i < NCH; i++) begin
                        wr_nx[i] = (ch == 4'(i));
                    end
                    cnt_nx = cnt + CW'(1);
                    if (cnt == LAST_IDX) begin
                        last_nx  = 1'b1;
                        state_nx = S_HUNT;
                    end
                end
                default: state_nx = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state         <= S_HUNT;
            ch            <= 4'h0;
            cnt           <= '0;
            bus.ch_data   <= 8'h00;
            bus.ch_wr     <= '0;
            bus.ch_last   <= 1'b0;
            bus.idle_seen <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.err_cnt   <= 8'h00;
        end else begin
            state         <= state_nx;
            ch            <= ch_nx;
            cnt           <= cnt_nx;
            bus.ch_data   <= data_nx;
            bus.ch_wr     <= wr_nx;
            bus.ch_last   <= last_nx;
            bus.idle_seen <= idle_nx;
            bus.frame_err <= err_nx;
            if (err_nx && bus.err_cnt != 8'hFF) begin
                bus.err_cnt <= bus.err_cnt + 8'd1;
            end
        end
    end
endmodule

`default_nettype wire
